// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int INST_W       = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO holding fetched {pc, instruction} entries, with
// a synchronous flush that empties it in one edge.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;
   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign head_data = entries[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a small
// instruction buffer, redirect/flush handling and misaligned-target faults.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BUF_DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [XLEN-1:0]   inst_pc,
   output logic              fetch_fault,
   output logic [XLEN-1:0]   fault_pc
);

   localparam int ENTRY_W = XLEN + INST_W;

   fetch_state_e       state, state_nxt;
   logic [XLEN-1:0]    fetch_pc, fetch_pc_nxt;
   logic               fault_nxt;
   logic [XLEN-1:0]    fault_pc_nxt;
   logic               req_fire;
   logic               rsp_pending;
   logic               redirect_aligned;
   logic               buf_push;
   logic               buf_pop;
   logic               buf_empty;
   logic               buf_full;
   logic [ENTRY_W-1:0] buf_head;

   assign req_fire         = imem_req_valid && imem_req_ready;
   assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
   // A response still owed by memory after this edge must be swallowed.
   assign rsp_pending      = ((state == ST_WAIT || state == ST_DROP) && !imem_rsp_valid)
                             || req_fire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         fetch_pc    <= RESET_VECTOR;
         fetch_fault <= 1'b0;
         fault_pc    <= '0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         fetch_fault <= fault_nxt;
         fault_pc    <= fault_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      fault_nxt    = fetch_fault;
      fault_pc_nxt = fault_pc;
      if (redirect_valid) begin
         if (redirect_aligned) begin
            fetch_pc_nxt = redirect_pc;
            fault_nxt    = 1'b0;
         end else begin
            fault_nxt    = 1'b1;
            fault_pc_nxt = redirect_pc;
         end
         if (rsp_pending)           state_nxt = ST_DROP;
         else if (redirect_aligned) state_nxt = ST_RUN;
         else                       state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_RUN: begin
               if (req_fire) begin
                  state_nxt    = ST_WAIT;
                  fetch_pc_nxt = fetch_pc + XLEN'(4);
               end
            end
            ST_WAIT:  if (imem_rsp_valid) state_nxt = ST_RUN;
            ST_DROP:  if (imem_rsp_valid) state_nxt = fetch_fault ? ST_FAULT : ST_RUN;
            default:  state_nxt = ST_FAULT;
         endcase
      end
   end

   always_comb begin
      imem_req_valid = reset && (state == ST_RUN) && !buf_full;
      imem_req_addr  = fetch_pc;
      buf_push       = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
      inst_valid     = !buf_empty;
      buf_pop        = inst_valid && inst_ready && !redirect_valid;
      inst_data      = buf_empty ? NOP_INST : buf_head[INST_W-1:0];
      inst_pc        = buf_head[ENTRY_W-1:INST_W];
   end

   // fetch_pc has already advanced past the outstanding request.
   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (buf_push),
      .push_data ({fetch_pc - XLEN'(4), imem_rsp_data}),
      .pop       (buf_pop),
      .head_data (buf_head),
      .empty     (buf_empty),
      .full      (buf_full)
   );

endmodule
